pong_playfield: RTL and testbench

// - Second-generation Pong screen generator. Owns the moving ball, the right-hand paddle,
//   the border, and the miss/score state.
// - Sits between the VGA timing generator (PIXEL_H/PIXEL_V, FRAME_START) and the DAC pins.
// - Updates game state once per frame and renders one registered pixel per VGA_CLOCK.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_ball_physics.sv | 130 +++++++++++++
 rtl/pong_playfield.sv | 86 ++++++++
 tb/tb_pong_playfield.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encoding, 3-bit {R,G,B} colours and the
// signed 12-bit coordinate type used by the physics and the renderer.
package pong_pkg;
  localparam int COORD_W = 12;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_MISSED = 2'd2
  } game_state_t;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;

  localparam coord_t ZERO = coord_t'(0);
  localparam coord_t ONE  = coord_t'(1);

  function automatic logic in_span(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val <= hi);
  endfunction
endpackage

// File: rtl/pong_ball_physics.sv
// Per-frame game state: serve/play/missed FSM, ball position and velocity,
// paddle latch. The SCORE counter exists only when PONG_SCORE_EN is defined.
module pong_ball_physics
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = 780,
  parameter int V_ACTIVE    = 478,
  parameter int PADDLE_X    = 700,
  parameter int PADDLE_H    = 50,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_SPEED  = 2,
  parameter int SERVE_DELAY = 60
) (
  input  logic       VGA_CLOCK,
  input  logic       RESET,
  input  logic       FRAME_START,
  input  logic [7:0] PADDLE_POSITION,
  output coord_t     ball_x,
  output coord_t     ball_y,
  output coord_t     paddle_y,
  output logic       MISS
`ifdef PONG_SCORE_EN
  ,
  output logic [7:0] SCORE
`endif
);
  localparam coord_t HA  = coord_t'(H_ACTIVE);
  localparam coord_t VA  = coord_t'(V_ACTIVE);
  localparam coord_t PX  = coord_t'(PADDLE_X);
  localparam coord_t PH  = coord_t'(PADDLE_H);
  localparam coord_t BS  = coord_t'(BALL_SIZE);
  localparam coord_t SPD = coord_t'(BALL_SPEED);
  localparam coord_t CX  = coord_t'(H_ACTIVE / 2);
  localparam coord_t CY  = coord_t'(V_ACTIVE / 2);
  localparam int SC_W = (SERVE_DELAY > 2) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_DELAY - 1);

  game_state_t     state, state_nx;
  logic [SC_W-1:0] serve_cnt;
  coord_t          dx, dy, adx, ady, nx, ny, pos_ext, pad_lat;
  logic            hit_top, hit_bot, hit_left, hit_pad, hit_miss;

  // Left wall beats the paddle, the paddle beats the miss line.
  always_comb begin
    adx      = dx[COORD_W-1] ? -dx : dx;
    ady      = dy[COORD_W-1] ? -dy : dy;
    nx       = ball_x + dx;
    ny       = ball_y + dy;
    hit_top  = (ny <= ZERO);
    hit_bot  = (ny + BS >= VA);
    hit_left = (nx <= ZERO);
    hit_pad  = !hit_left && (dx > ZERO) && (ball_x + BS <= PX) && (nx + BS > PX) &&
               (ball_y <= paddle_y + PH) && (ball_y + BS - ONE >= paddle_y);
    hit_miss = !hit_left && !hit_pad && (nx + BS >= HA);
    pos_ext  = coord_t'({4'b0000, PADDLE_POSITION});
    pad_lat  = (pos_ext + PH > VA - ONE) ? (VA - ONE - PH) : pos_ext;
  end

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) state <= ST_SERVE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (FRAME_START) begin
      case (state)
        ST_SERVE:  if (serve_cnt == SERVE_LAST) state_nx = ST_PLAY;
        ST_PLAY:   if (hit_miss) state_nx = ST_MISSED;
        ST_MISSED: state_nx = ST_SERVE;
        default:   state_nx = ST_SERVE;
      endcase
    end
  end

  always_comb begin
    MISS = 1'b0;
    if (FRAME_START && (state == ST_MISSED)) MISS = 1'b1;
  end

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      serve_cnt <= '0;
      ball_x    <= CX;
      ball_y    <= CY;
      dx        <= SPD;
      dy        <= SPD;
      paddle_y  <= ZERO;
    end else if (FRAME_START) begin
      paddle_y <= pad_lat;
      case (state)
        ST_SERVE: serve_cnt <= (serve_cnt == SERVE_LAST) ? '0 : serve_cnt + 1'b1;
        ST_PLAY: begin
          if (hit_top) begin
            ball_y <= ONE;
            dy     <= ady;
          end else if (hit_bot) begin
            ball_y <= VA - ONE - BS;
            dy     <= -ady;
          end else begin
            ball_y <= ny;
          end
          if (hit_left) begin
            ball_x <= ONE;
            dx     <= adx;
          end else if (hit_pad) begin
            ball_x <= PX - BS;
            dx     <= -adx;
          end else begin
            ball_x <= nx;
          end
        end
        ST_MISSED: begin
          ball_x <= CX;
          ball_y <= CY;
          dx     <= SPD;
        end
        default: ;
      endcase
    end
  end

`ifdef PONG_SCORE_EN
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET)                                                  SCORE <= 8'd0;
    else if (MISS)                                              SCORE <= 8'd0;
    else if (FRAME_START && state == ST_PLAY && hit_pad && SCORE != 8'hFF) SCORE <= SCORE + 8'd1;
  end
`endif
endmodule

// File: rtl/pong_playfield.sv
// Pong screen generator: game physics plus a one-cycle registered pixel renderer.
// Define PONG_SCORE_EN to add the SCORE port and the blue score bar.
module pong_playfield
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = 780,
  parameter int V_ACTIVE    = 478,
  parameter int PADDLE_X    = 700,
  parameter int PADDLE_W    = 50,
  parameter int PADDLE_H    = 50,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_SPEED  = 2,
  parameter int SERVE_DELAY = 60,
  parameter int COLOR_BITS  = 1
) (
  input  logic                    VGA_CLOCK,
  input  logic                    RESET,
  input  logic                    FRAME_START,
  input  logic [7:0]              PADDLE_POSITION,
  input  logic [10:0]             PIXEL_H,
  input  logic [10:0]             PIXEL_V,
  output logic [3*COLOR_BITS-1:0] PIXEL,
  output logic                    MISS
`ifdef PONG_SCORE_EN
  ,
  output logic [7:0]              SCORE
`endif
);
  localparam coord_t HA = coord_t'(H_ACTIVE);
  localparam coord_t VA = coord_t'(V_ACTIVE);
  localparam coord_t PX = coord_t'(PADDLE_X);
  localparam coord_t PW = coord_t'(PADDLE_W);
  localparam coord_t PH = coord_t'(PADDLE_H);
  localparam coord_t BS = coord_t'(BALL_SIZE);

  coord_t     ball_x, ball_y, paddle_y, h, v;
  logic [2:0] colour;

  pong_ball_physics #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .PADDLE_X   (PADDLE_X),
    .PADDLE_H   (PADDLE_H),
    .BALL_SIZE  (BALL_SIZE),
    .BALL_SPEED (BALL_SPEED),
    .SERVE_DELAY(SERVE_DELAY)
  ) u_physics (
    .VGA_CLOCK      (VGA_CLOCK),
    .RESET          (RESET),
    .FRAME_START    (FRAME_START),
    .PADDLE_POSITION(PADDLE_POSITION),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .paddle_y       (paddle_y),
    .MISS           (MISS)
`ifdef PONG_SCORE_EN
    ,
    .SCORE          (SCORE)
`endif
  );

  always_comb begin
    h      = coord_t'({1'b0, PIXEL_H});
    v      = coord_t'({1'b0, PIXEL_V});
    colour = COL_BLACK;
    if (h <= HA && v <= VA) begin
      if (v == ZERO || v == VA || h == ZERO || h == HA)
        colour = COL_RED;
      else if (in_span(h, ball_x, ball_x + BS - ONE) && in_span(v, ball_y, ball_y + BS - ONE))
        colour = COL_GREEN;
      else if (in_span(h, PX, PX + PW) && in_span(v, paddle_y, paddle_y + PH))
        colour = COL_WHITE;
`ifdef PONG_SCORE_EN
      else if (in_span(v, coord_t'(2), coord_t'(5)) &&
               in_span(h, coord_t'(2), coord_t'(2) + coord_t'({4'b0000, SCORE})))
        colour = COL_BLUE;
`endif
    end
  end

  // Each lit channel drives every one of its bits.
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) PIXEL <= '0;
    else       PIXEL <= {{COLOR_BITS{colour[2]}}, {COLOR_BITS{colour[1]}}, {COLOR_BITS{colour[0]}}};
  end
endmodule

// File: tb/tb_pong_playfield.sv
// Scoreboard bench for pong_playfield on a 100x40 field so ball paths are traceable by hand.
// Build with PONG_SCORE_EN defined to also cover SCORE and the score bar.
module tb_pong_playfield;
  localparam logic [5:0] BLK = 6'b000000;
  localparam logic [5:0] RED = 6'b110000;
  localparam logic [5:0] GRN = 6'b001100;
  localparam logic [5:0] BLU = 6'b000011;
  localparam logic [5:0] WHT = 6'b111111;
`ifdef PONG_SCORE_EN
  localparam logic [5:0] BAR_C2_S0 = BLU;
  localparam logic [5:0] BAR_C3_S1 = BLU;
`else
  localparam logic [5:0] BAR_C2_S0 = BLK;
  localparam logic [5:0] BAR_C3_S1 = BLK;
`endif

  logic        clk = 1'b0;
  logic        rst, fs;
  logic [7:0]  pp;
  logic [10:0] ph, pv;
  logic [5:0]  pixel;
  logic        miss;
`ifdef PONG_SCORE_EN
  logic [7:0]  score;
`endif

  always #5 clk = ~clk;

  pong_playfield #(
    .H_ACTIVE(100), .V_ACTIVE(40), .PADDLE_X(80), .PADDLE_W(6), .PADDLE_H(10),
    .BALL_SIZE(4), .BALL_SPEED(2), .SERVE_DELAY(3), .COLOR_BITS(2)
  ) dut (
    .VGA_CLOCK(clk), .RESET(rst), .FRAME_START(fs), .PADDLE_POSITION(pp),
    .PIXEL_H(ph), .PIXEL_V(pv), .PIXEL(pixel), .MISS(miss)
`ifdef PONG_SCORE_EN
    , .SCORE(score)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  logic [5:0] pix_q[$];
  string      name_q[$];
  logic       miss_q[$];
  logic       probe = 1'b0;
  logic       pend = 1'b0;
  logic [5:0] exp_px;
  logic       exp_miss;
  string      nm;

  always @(posedge clk) pend <= probe;

  // Monitor: a probe captured on the last edge is now on PIXEL; MISS is checked on every strobe.
  always @(negedge clk) begin
    if (!rst && pend) begin
      checks++;
      if (pix_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: PIXEL=%b with nothing expected", pixel);
      end else begin
        exp_px = pix_q.pop_front();
        nm     = name_q.pop_front();
        if (pixel !== exp_px) begin
          errors++;
          $display("FAIL %s: PIXEL=%b expected %b", nm, pixel, exp_px);
        end
      end
    end
    if (!rst && fs) begin
      checks++;
      if (miss_q.size() == 0) begin
        errors++;
        $display("FAIL miss_unexpected: MISS=%b with nothing expected", miss);
      end else begin
        exp_miss = miss_q.pop_front();
        if (miss !== exp_miss) begin
          errors++;
          $display("FAIL miss_pulse: MISS=%b expected %b", miss, exp_miss);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic px(input int h, input int v, input logic [5:0] e, input string name);
    ph    = 11'(h);
    pv    = 11'(v);
    probe = 1'b1;
    pix_q.push_back(e);
    name_q.push_back(name);
    tick();
    probe = 1'b0;
  endtask

  task automatic frame(input logic em);
    fs = 1'b1;
    miss_q.push_back(em);
    tick();
    fs = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0);
  endtask

  task automatic ball(input int x, input int y, input string name);
    px(x, y, GRN, name);
    px(x + 3, y + 3, GRN, {name, "_far"});
    px(x - 1, y, BLK, {name, "_left"});
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; pp = 8'd0; ph = '0; pv = '0;
    repeat (3) tick();
    chk("reset_pixel", 32'(pixel), 0);
    chk("reset_miss", 32'(miss), 0);
    rst = 1'b0;

    ball(50, 20, "reset_ball");
    px(54, 20, BLK, "ball_right_edge");
    px(0, 0, RED, "corner");
    px(100, 5, RED, "right_border");
    px(5, 40, RED, "bottom_border");
    px(101, 5, BLK, "offscreen_h");
    px(5, 41, BLK, "offscreen_v");
    px(80, 5, WHT, "paddle");
    px(86, 10, WHT, "paddle_far");
    px(87, 5, BLK, "paddle_right");
    px(80, 11, BLK, "paddle_below");
    px(2, 3, BAR_C2_S0, "bar_score0");
    px(3, 3, BLK, "bar_score0_c3");
    px(60, 20, BLK, "latency_a");
    px(50, 20, GRN, "latency_b");
    px(60, 20, BLK, "latency_c");

    frames(3);
    ball(50, 20, "serve_hold");
    frames(1);  ball(52, 22, "play_k1");
    frames(6);  ball(64, 34, "play_k7");
    frames(1);  ball(66, 35, "bottom_clamp");
    px(66, 39, BLK, "bottom_gap");
    px(66, 34, BLK, "bottom_above");
    frames(1);  ball(68, 33, "bottom_dy_up");
    px(68, 37, BLK, "bottom_dy_up_below");
    frames(5);
    pp = 8'd20;
    frames(1);
    px(81, 22, GRN, "ball_over_paddle");
    px(85, 22, WHT, "paddle_beside_ball");
    px(80, 20, WHT, "paddle_top_row");
    px(87, 22, BLK, "paddle_right2");
    frames(7);  ball(94, 7, "pre_miss");
    frames(1);
    frame(1'b1);
    ball(50, 20, "recentre");
    px(94, 7, BLK, "old_ball_gone");
`ifdef PONG_SCORE_EN
    chk("score_after_miss", 32'(score), 0);
`endif

    pp = 8'd255;
    frames(1);
    px(80, 40, RED, "clamp_border");
    px(80, 39, WHT, "clamp_bottom_row");
    px(80, 28, BLK, "clamp_above");
    px(86, 29, WHT, "clamp_top_row");

    pp = 8'd5;
    frames(2);
    frames(9);  ball(68, 2, "top_approach");
    px(68, 1, BLK, "top_approach_above");
    frames(1);  ball(70, 1, "top_clamp");
    px(70, 0, RED, "top_border");
    px(70, 5, BLK, "top_clamp_below");
    frames(1);  ball(72, 3, "top_dy_down");
    px(72, 2, BLK, "top_dy_down_above");
    frames(3);  ball(76, 9, "paddle_return");
    px(80, 9, WHT, "paddle_next_to_ball");
    px(3, 3, BAR_C3_S1, "bar_score1");
`ifdef PONG_SCORE_EN
    chk("score_after_hit", 32'(score), 1);
`endif
    frames(1);  ball(74, 11, "dx_reversed");
    px(78, 11, BLK, "dx_reversed_right");

    px(0, 5, RED, "pre_reset_border");
    tick();
    #2 rst = 1'b1;
    #1 chk("async_reset_pixel", 32'(pixel), 0);
    chk("async_reset_miss", 32'(miss), 0);
`ifdef PONG_SCORE_EN
    chk("async_reset_score", 32'(score), 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    ball(50, 20, "post_reset_ball");
    px(74, 11, BLK, "post_reset_old_ball");
    frames(1);
    ball(50, 20, "post_reset_serve");

    tick();
    tick();
    chk("scoreboard_drained", 32'(pix_q.size() + miss_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
